// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze game controller:
//   - move_e   : joystick move codes (codes 5..7 are decoded as MV_NONE)
//   - state_e  : 4-bit controller FSM encodings, exported on state_cur
//   - COL_*    : plot colour constants
//   - decode_move() : maps a raw 3-bit move code onto move_e
// -----------------------------------------------------------------------------
package maze_pkg;

    typedef enum logic [2:0] {
        MV_NONE  = 3'd0,
        MV_LEFT  = 3'd1,
        MV_RIGHT = 3'd2,
        MV_UP    = 3'd3,
        MV_DOWN  = 3'd4
    } move_e;

    typedef enum logic [3:0] {
        ST_INIT       = 4'd0,
        ST_WAIT_TIMER = 4'd1,
        ST_ERASE      = 4'd2,
        ST_READ_KEY   = 4'd3,
        ST_LOOK       = 4'd4,
        ST_OBS_WAIT   = 4'd5,
        ST_TEST_OBS   = 4'd6,
        ST_UPDATE_POS = 4'd7,
        ST_DRAW       = 4'd8,
        ST_CHECK_WIN  = 4'd9,
        ST_WIN        = 4'd10
    } state_e;

    localparam logic COL_ERASE  = 1'b0;
    localparam logic COL_PLAYER = 1'b1;

    // Unused codes 5..7 behave exactly like "no key pressed".
    function automatic move_e decode_move(input logic [2:0] code);
        move_e m;
        case (code)
            3'd1:    m = MV_LEFT;
            3'd2:    m = MV_RIGHT;
            3'd3:    m = MV_UP;
            3'd4:    m = MV_DOWN;
            default: m = MV_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/maze_ctrl_gen_if.sv
// -----------------------------------------------------------------------------
// maze_ctrl_gen_if
// Bus bundle between the maze controller and its two peers.
//   Obstacle memory : obs_rd (1-cycle strobe), obs_x/obs_y (lookup cell),
//                     obs_block (wall flag, valid OBS_LAT cycles after obs_rd)
//   Pixel plotter   : draw_req/draw_color/draw_x/draw_y, draw_ack
// Handshake: draw_req rises with colour and coordinates and all of them stay
// constant until the cycle in which draw_ack is high (a one-cycle pulse); that
// cycle completes the transfer, including when ack arrives in the very first
// cycle of the request. draw_ack while no request is pending is ignored.
// Modports: master = controller, slave = memory/plotter side.
// -----------------------------------------------------------------------------
interface maze_ctrl_gen_if #(
    parameter int X_W = 5,
    parameter int Y_W = 4
);
    logic           obs_rd;
    logic [X_W-1:0] obs_x;
    logic [Y_W-1:0] obs_y;
    logic           obs_block;
    logic           draw_req;
    logic           draw_color;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           draw_ack;

    modport master (
        output obs_rd, obs_x, obs_y,
        input  obs_block,
        output draw_req, draw_color, draw_x, draw_y,
        input  draw_ack
    );

    modport slave (
        input  obs_rd, obs_x, obs_y,
        output obs_block,
        input  draw_req, draw_color, draw_x, draw_y,
        output draw_ack
    );
endinterface

// File: rtl/maze_frame_timer.sv
// -----------------------------------------------------------------------------
// maze_frame_timer
// Frame tick counter. Counts enabled cycles 0..TICKS-1; done_o is high in the
// enabled cycle holding TICKS-1, and the counter wraps to 0 on that edge, so
// the frame lasts exactly TICKS enabled cycles.
// Ports:
//   clk, reset : clock, asynchronous active-low reset (count -> 0)
//   en_i       : count this cycle
//   clr_i      : synchronous clear (has priority over en_i)
//   done_o     : last tick of the frame
// -----------------------------------------------------------------------------
module maze_frame_timer #(
    parameter int TICKS = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic done_o
);
    localparam int CNT_W = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || done_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/maze_ctrl_gen.sv
// -----------------------------------------------------------------------------
// maze_ctrl_gen
// Maze game controller: owns player position, frame timer and the obstacle
// lookup sequence; plots erase/player pixels through a req/ack plotter; clamps
// moves at the grid edge and latches a win when the goal cell is reached.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   move       : 0 none, 1 left, 2 right, 3 up, 4 down (5..7 = none)
//   bus        : maze_ctrl_gen_if.master (obstacle memory + plotter)
//   xpos, ypos : player position
//   win        : latched goal reached
//   state_cur  : FSM state code (maze_pkg::state_e)
//   steps      : moves taken, saturating (only with MAZE_STEP_COUNT_EN)
// Optional feature macro: MAZE_STEP_COUNT_EN
// -----------------------------------------------------------------------------
module maze_ctrl_gen
    import maze_pkg::*;
#(
    parameter int X_W     = 5,
    parameter int Y_W     = 4,
    parameter int X_MAX   = 19,
    parameter int Y_MAX   = 14,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 19,
    parameter int GOAL_Y  = 14,
    parameter int TICKS   = 833333,
    parameter int OBS_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        move,
    maze_ctrl_gen_if.master   bus,
    output logic [X_W-1:0]    xpos,
    output logic [Y_W-1:0]    ypos,
    output logic              win,
    output logic [3:0]        state_cur
`ifdef MAZE_STEP_COUNT_EN
    ,
    output logic [15:0]       steps
`endif
);
    localparam logic [X_W-1:0] X_LAST  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_GOAL  = X_W'(GOAL_X);
    localparam logic [Y_W-1:0] Y_GOAL  = Y_W'(GOAL_Y);
    // OBS_WAIT lasts OBS_LAT-1 cycles; wait_q counts 0..OBS_LAT-2 there.
    localparam int WAIT_W = (OBS_LAT > 2) ? $clog2(OBS_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((OBS_LAT > 1) ? OBS_LAT - 2 : 0);

    state_e            state_q, state_d;
    logic [X_W-1:0]    xpos_q, xpos_d;
    logic [Y_W-1:0]    ypos_q, ypos_d;
    logic              win_q, win_d;
    move_e             mv_q, mv_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
`ifdef MAZE_STEP_COUNT_EN
    logic [15:0]       steps_q, steps_d;
`endif

    logic              timer_en, timer_clr, timer_done;
    move_e             tgt_mv;
    logic [X_W-1:0]    tgt_x;
    logic [Y_W-1:0]    tgt_y;
    logic              off_grid;

    maze_frame_timer #(.TICKS(TICKS)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (timer_en),
        .clr_i  (timer_clr),
        .done_o (timer_done)
    );

    // Target cell. In READ_KEY the live key is used so the branch decision
    // is made in the same cycle the key is latched; afterwards the latched
    // move drives it, keeping obs_x/obs_y stable through TEST_OBS.
    always_comb begin
        tgt_mv   = (state_q == ST_READ_KEY) ? decode_move(move) : mv_q;
        tgt_x    = xpos_q;
        tgt_y    = ypos_q;
        off_grid = 1'b0;
        case (tgt_mv)
            MV_LEFT:  if (xpos_q == '0)     off_grid = 1'b1; else tgt_x = xpos_q - 1'b1;
            MV_RIGHT: if (xpos_q >= X_LAST) off_grid = 1'b1; else tgt_x = xpos_q + 1'b1;
            MV_UP:    if (ypos_q == '0)     off_grid = 1'b1; else tgt_y = ypos_q - 1'b1;
            MV_DOWN:  if (ypos_q >= Y_LAST) off_grid = 1'b1; else tgt_y = ypos_q + 1'b1;
            default:  off_grid = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        win_d     = win_q;
        mv_d      = mv_q;
        wait_d    = wait_q;
        timer_en  = 1'b0;
        timer_clr = 1'b0;
`ifdef MAZE_STEP_COUNT_EN
        steps_d   = steps_q;
`endif
        case (state_q)
            ST_INIT: begin
                xpos_d    = X_START;
                ypos_d    = Y_START;
                win_d     = 1'b0;
                timer_clr = 1'b1;
`ifdef MAZE_STEP_COUNT_EN
                steps_d   = '0;
`endif
                state_d   = ST_WAIT_TIMER;
            end
            ST_WAIT_TIMER: begin
                timer_en = 1'b1;
                if (timer_done) state_d = ST_ERASE;
            end
            ST_ERASE: begin
                if (bus.draw_ack) state_d = ST_READ_KEY;
            end
            ST_READ_KEY: begin
                mv_d    = tgt_mv;
                state_d = ((tgt_mv == MV_NONE) || off_grid) ? ST_DRAW : ST_LOOK;
            end
            ST_LOOK: begin
                wait_d  = '0;
                state_d = (OBS_LAT > 1) ? ST_OBS_WAIT : ST_TEST_OBS;
            end
            ST_OBS_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = ST_TEST_OBS;
                else                     wait_d  = wait_q + 1'b1;
            end
            ST_TEST_OBS: begin
                state_d = bus.obs_block ? ST_DRAW : ST_UPDATE_POS;
            end
            ST_UPDATE_POS: begin
                xpos_d  = tgt_x;
                ypos_d  = tgt_y;
`ifdef MAZE_STEP_COUNT_EN
                if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
`endif
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (bus.draw_ack) state_d = ST_CHECK_WIN;
            end
            ST_CHECK_WIN: begin
                if ((xpos_q == X_GOAL) && (ypos_q == Y_GOAL)) begin
                    win_d   = 1'b1;
                    state_d = ST_WIN;
                end else begin
                    state_d = ST_WAIT_TIMER;
                end
            end
            ST_WIN:  state_d = ST_WIN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            xpos_q  <= X_START;
            ypos_q  <= Y_START;
            win_q   <= 1'b0;
            mv_q    <= MV_NONE;
            wait_q  <= '0;
`ifdef MAZE_STEP_COUNT_EN
            steps_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            win_q   <= win_d;
            mv_q    <= mv_d;
            wait_q  <= wait_d;
`ifdef MAZE_STEP_COUNT_EN
            steps_q <= steps_d;
`endif
        end
    end

    // Bus outputs are decoded from the state register, so an asynchronous
    // reset drops draw_req and obs_rd immediately.
    assign bus.obs_rd     = (state_q == ST_LOOK);
    assign bus.obs_x      = tgt_x;
    assign bus.obs_y      = tgt_y;
    assign bus.draw_req   = (state_q == ST_ERASE) || (state_q == ST_DRAW);
    assign bus.draw_color = (state_q == ST_DRAW) ? COL_PLAYER : COL_ERASE;
    assign bus.draw_x     = xpos_q;
    assign bus.draw_y     = ypos_q;

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign win       = win_q;
    assign state_cur = state_q;
`ifdef MAZE_STEP_COUNT_EN
    assign steps     = steps_q;
`endif
endmodule

// File: doc/maze_ctrl_gen.md
Name: maze_ctrl_gen

Overview:
- Next-generation maze game controller.
- Owns the player position, the frame timer and the obstacle-lookup sequencing.
- Talks to the obstacle memory with a parametrised read latency, and to the pixel plotter with a req/ack handshake.
- Adds grid-edge clamping, goal/win detection and a latched win state.

Parameters:
- X_W, 5, width of the x coordinate
- Y_W, 4, width of the y coordinate
- X_MAX, 19, last legal x column
- Y_MAX, 14, last legal y row
- START_X, 0, x loaded at reset/INIT
- START_Y, 0, y loaded at reset/INIT
- GOAL_X, 19, goal column
- GOAL_Y, 14, goal row
- TICKS, 833333, clk cycles per frame (must be >=2)
- OBS_LAT, 1, cycles from obs_rd to a valid obs_block (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- move  in  3  0 NONE, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN; 5-7 treated as NONE
- obs_rd  out  1  one-cycle obstacle-memory read strobe
- obs_x  out  X_W  lookup column
- obs_y  out  Y_W  lookup row
- obs_block  in  1  1 = target cell is a wall; valid OBS_LAT cycles after obs_rd
- draw_req  out  1  plot request; held until draw_ack
- draw_color  out  1  0 erase, 1 player
- draw_x  out  X_W  plot column (current xpos)
- draw_y  out  Y_W  plot row (current ypos)
- draw_ack  in  1  plotter done; single-cycle pulse
- xpos  out  X_W  player column
- ypos  out  Y_W  player row
- win  out  1  latched goal reached
- state_cur  out  4  FSM state code, for debug

Behaviour:
- Reset (async, active-low): state=INIT, xpos=START_X, ypos=START_Y, timer=0, win=0, obs_rd=0, draw_req=0, draw_color=0, mv=NONE.
- All other registers update on the clk rising edge.
- INIT: reload position, timer and win -> WAIT_TIMER.
- WAIT_TIMER: timer++.
  - When timer==TICKS-1: clear timer -> ERASE.
  - Frame period is therefore exactly TICKS cycles from WAIT_TIMER entry.
- ERASE: draw_req=1, draw_color=0.
  - Hold all draw outputs stable until the cycle draw_ack=1 -> READ_KEY.
- READ_KEY: latch move into mv (codes 5-7 become NONE).
  - mv==NONE -> DRAW.
  - Target cell off-grid (x==0&LEFT, x==X_MAX&RIGHT, y==0&UP, y==Y_MAX&DOWN) -> DRAW; no memory read issued.
  - Otherwise -> LOOK.
- LOOK: obs_rd=1 for one cycle; obs_x/obs_y = target cell -> OBS_WAIT.
  - obs_x/obs_y are held stable until TEST_OBS.
- OBS_WAIT: count OBS_LAT-1 cycles (0 cycles when OBS_LAT=1) -> TEST_OBS.
- TEST_OBS: sample obs_block.
  - 1 -> DRAW.
  - 0 -> UPDATE_POS.
- UPDATE_POS: apply +/-1 to xpos or ypos per mv -> DRAW.
- DRAW: draw_req=1, draw_color=1 at the current position.
  - On draw_ack -> CHECK_WIN.
- CHECK_WIN: xpos==GOAL_X && ypos==GOAL_Y -> set win, go to WIN; else -> WAIT_TIMER.
- WIN: terminal; outputs idle, win=1. Left only by reset.
- draw_ack outside ERASE/DRAW is ignored.
- draw_ack in the same cycle draw_req rises is accepted.
- move changes outside READ_KEY have no effect.
- Reset mid-handshake drops draw_req immediately, asynchronously.
- Position never leaves 0..X_MAX / 0..Y_MAX. There is no wrap-around.

Optional Feature:
- Macro: MAZE_STEP_COUNT_EN.
- Defined:
  - Adds output steps[15:0].
  - Cleared at reset/INIT; +1 per UPDATE_POS.
  - Saturates at 16'hFFFF; frozen in WIN.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package maze_pkg:
  - move codes (MV_NONE..MV_DOWN)
  - state encodings (INIT..WIN, 4-bit)
  - color constants (COL_ERASE=0, COL_PLAYER=1)
- One natural sub-module: maze_frame_timer.
  - Parametrised TICKS counter with en/clr inputs and a done output.
- Target-cell computation and FSM stay in the top.

Test Plan (TICKS=4, OBS_LAT=2, defaults otherwise):
- Reset released, move=0, draw_ack tied high.
  - Frame: WAIT_TIMER 4 cycles, erase plot at (0,0), player plot at (0,0).
  - No obs_rd. xpos/ypos stay 0.
- move=RIGHT, obs_block=0.
  - obs_rd pulses with obs_x=1, obs_y=0.
  - TEST_OBS exactly 2 cycles after obs_rd.
  - xpos=1 before the DRAW request.
- move=DOWN at (1,0) with obs_block=1.
  - obs_y=1 read issued; position stays (1,0); DRAW at (1,0).
- move=LEFT at (0,0) and move=UP at (0,0).
  - No obs_rd; position unchanged.
  - Repeat at (19,14) with RIGHT/DOWN: same, no read, no change.
- Drive position to (19,13), then move=DOWN, obs_block=0.
  - Position becomes (19,14); win=1 in the cycle after CHECK_WIN.
  - FSM stays in WIN; further moves and ticks are ignored.
- draw_ack delayed 5 cycles during ERASE; async reset asserted mid-DRAW.
  - draw_req and draw_x/draw_y stable for all 5 cycles.
  - On reset: draw_req=0, state=INIT, position=(0,0), win=0 immediately.
